// File: rtl/puf_race_controller_if.sv
// Host-side handshake bundle for the RO-PUF race controller: evaluation
// request, response word with valid/ready, and per-response status flags.
interface puf_race_controller_if #(
  parameter int RESP_BITS = 16,
  parameter int SEL_W     = 5
);
  logic                 start;
  logic [SEL_W-1:0]     challenge;
  logic                 busy;
  logic [RESP_BITS-1:0] resp;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 tie_flag;
  logic                 to_flag;

  modport master (
    output start, challenge, resp_ready,
    input  busy, resp, resp_valid, tie_flag, to_flag
  );

  modport slave (
    input  start, challenge, resp_ready,
    output busy, resp, resp_valid, tie_flag, to_flag
  );
endinterface

// File: rtl/puf_race_controller.sv
// RO-PUF race sequencer: for each challenge pair it selects two oscillators,
// clears and settles the race counters, enables them until one finishes (or
// the race times out), and packs one bit per pair into the response word.
module puf_race_controller #(
  parameter int RESP_BITS  = 16,
  parameter int SEL_W      = 5,
  parameter int CLR_CYCLES = 2,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 2**23
) (
  input  logic                 clk,
  input  logic                 reset,
  puf_race_controller_if.slave host,
  input  logic                 fin_a,
  input  logic                 fin_b,
  output logic [SEL_W-1:0]     sel_a,
  output logic [SEL_W-1:0]     sel_b,
  output logic                 cnt_reset,
  output logic                 cnt_enable
);

  localparam int IDX_W   = $clog2(RESP_BITS);
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam int CYC_MAX = (CLR_CYCLES > SETTLE_CYC) ? CLR_CYCLES : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    RACE,
    RECORD,
    DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   bit_idx;
  logic [TMR_W-1:0]   timer;
  logic [CYC_W-1:0]   cyc;
  logic               race_bit;

  // Single registered FSM; the mux selects carry the latched challenge and
  // advance by two per pair, so mod-2**SEL_W wrap falls out of the adder width.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt_reset       <= 1'b1;
      cnt_enable      <= 1'b0;
      sel_a           <= '0;
      sel_b           <= '0;
      host.busy       <= 1'b0;
      host.resp       <= '0;
      host.resp_valid <= 1'b0;
      host.tie_flag   <= 1'b0;
      host.to_flag    <= 1'b0;
      bit_idx         <= '0;
      timer           <= '0;
      cyc             <= '0;
      race_bit        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_reset  <= 1'b1;
          cnt_enable <= 1'b0;
          if (host.start) begin
            sel_a         <= host.challenge;
            sel_b         <= host.challenge + SEL_W'(1);
            host.tie_flag <= 1'b0;
            host.to_flag  <= 1'b0;
            host.resp     <= '0;
            host.busy     <= 1'b1;
            bit_idx       <= '0;
            cyc           <= '0;
            state         <= CLEAR;
          end
        end

        CLEAR: begin
          if (cyc == CYC_W'(CLR_CYCLES - 1)) begin
            cyc       <= '0;
            cnt_reset <= 1'b0;
            state     <= SETTLE;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        SETTLE: begin
          if (cyc == CYC_W'(SETTLE_CYC - 1)) begin
            cyc        <= '0;
            timer      <= '0;
            cnt_enable <= 1'b1;
            state      <= RACE;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        RACE: begin
          timer <= timer + TMR_W'(1);
          if (fin_a && fin_b) begin
            race_bit      <= 1'b0;
            host.tie_flag <= 1'b1;
            cnt_enable    <= 1'b0;
            state         <= RECORD;
          end else if (fin_a) begin
            race_bit   <= 1'b1;
            cnt_enable <= 1'b0;
            state      <= RECORD;
          end else if (fin_b) begin
            race_bit   <= 1'b0;
            cnt_enable <= 1'b0;
            state      <= RECORD;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            race_bit     <= 1'b0;
            host.to_flag <= 1'b1;
            cnt_enable   <= 1'b0;
            state        <= RECORD;
          end
        end

        RECORD: begin
          host.resp[bit_idx] <= race_bit;
          cnt_reset          <= 1'b1;
          if (bit_idx == IDX_W'(RESP_BITS - 1)) begin
            host.resp_valid <= 1'b1;
            state           <= DONE;
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
            sel_a   <= sel_a + SEL_W'(2);
            sel_b   <= sel_b + SEL_W'(2);
            state   <= CLEAR;
          end
        end

        DONE: begin
          cnt_reset <= 1'b1;
          if (host.resp_ready) begin
            host.resp_valid <= 1'b0;
            host.busy       <= 1'b0;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_race_controller.sv
// Directed bench for puf_race_controller with a 4-bit response, 5-bit selects
// and a 64-cycle race timeout; a bench-side stand-in for the counters drives
// fin_a/fin_b a chosen number of enable cycles into each race.
module tb_puf_race_controller;

  localparam int RESP_BITS  = 4;
  localparam int SEL_W      = 5;
  localparam int CLR_CYCLES = 2;
  localparam int SETTLE_CYC = 4;
  localparam int TIMEOUT    = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             fin_a;
  logic             fin_b;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             cnt_reset;
  logic             cnt_enable;

  int checks   = 0;
  int failures = 0;

  puf_race_controller_if #(.RESP_BITS(RESP_BITS), .SEL_W(SEL_W)) host ();

  puf_race_controller #(
    .RESP_BITS (RESP_BITS),
    .SEL_W     (SEL_W),
    .CLR_CYCLES(CLR_CYCLES),
    .SETTLE_CYC(SETTLE_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (host.slave),
    .fin_a     (fin_a),
    .fin_b     (fin_b),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .cnt_reset (cnt_reset),
    .cnt_enable(cnt_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Accept an evaluation request; busy and the first pair's selects appear one edge later.
  task automatic start_eval(input logic [SEL_W-1:0] chal);
    host.start     = 1'b1;
    host.challenge = chal;
    @(negedge clk);
    host.start = 1'b0;
    check("start_busy", 32'(host.busy), 32'd1);
    check("start_cnt_reset", 32'(cnt_reset), 32'd1);
  endtask

  // One race: wait for enable, check selects, raise fins after 'delay' enable cycles.
  task automatic race_pair(input string tag, input int ea, input int eb, input int delay,
                           input logic fa, input logic fb, input int exp_n);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (cnt_enable) seen = 1'b1;
    end
    check({tag, "_enable_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_sel_a"}, 32'(sel_a), 32'(ea));
      check({tag, "_sel_b"}, 32'(sel_b), 32'(eb));
      check({tag, "_cnt_reset_low"}, 32'(cnt_reset), 32'd0);
      for (int i = 0; i < 200; i++) begin
        if (!cnt_enable) break;
        n++;
        if (n == delay) begin
          fin_a = fa;
          fin_b = fb;
        end
        @(negedge clk);
      end
      fin_a = 1'b0;
      fin_b = 1'b0;
      check({tag, "_enable_cycles"}, 32'(n), 32'(exp_n));
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (host.resp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic collect(input string tag, input logic [RESP_BITS-1:0] exp_resp,
                         input logic exp_tie, input logic exp_to);
    wait_valid(tag);
    check({tag, "_resp"}, 32'(host.resp), 32'(exp_resp));
    check({tag, "_tie"}, 32'(host.tie_flag), 32'(exp_tie));
    check({tag, "_to"}, 32'(host.to_flag), 32'(exp_to));
    check({tag, "_done_cnt_reset"}, 32'(cnt_reset), 32'd1);
    host.resp_ready = 1'b1;
    @(negedge clk);
    host.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(host.resp_valid), 32'd0);
    check({tag, "_busy_drop"}, 32'(host.busy), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    fin_a           = 1'b0;
    fin_b           = 1'b0;
    host.start      = 1'b0;
    host.challenge  = '0;
    host.resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cnt_reset", 32'(cnt_reset), 32'd1);
    check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    check("rst_sel_a", 32'(sel_a), 32'd0);
    check("rst_sel_b", 32'(sel_b), 32'd0);
    check("rst_busy", 32'(host.busy), 32'd0);
    check("rst_resp", 32'(host.resp), 32'd0);
    check("rst_valid", 32'(host.resp_valid), 32'd0);
    check("rst_tie", 32'(host.tie_flag), 32'd0);
    check("rst_to", 32'(host.to_flag), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset held 3 cycles while racing
    start_eval(5'd0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (cnt_enable) seen = 1'b1;
      end
      check("t1_enable_seen", 32'(seen), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("t1_cnt_reset", 32'(cnt_reset), 32'd1);
    check("t1_cnt_enable", 32'(cnt_enable), 32'd0);
    check("t1_valid", 32'(host.resp_valid), 32'd0);
    check("t1_busy", 32'(host.busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2: challenge 0, fin_a ten cycles into every race
    start_eval(5'd0);
    race_pair("t2_p0", 0, 1, 10, 1'b1, 1'b0, 10);
    race_pair("t2_p1", 2, 3, 10, 1'b1, 1'b0, 10);
    race_pair("t2_p2", 4, 5, 10, 1'b1, 1'b0, 10);
    race_pair("t2_p3", 6, 7, 10, 1'b1, 1'b0, 10);
    collect("t2", 4'b1111, 1'b0, 1'b0);

    // 3: challenge 30 wraps the selects; alternating winners
    start_eval(5'd30);
    race_pair("t3_p0", 30, 31, 7, 1'b1, 1'b0, 7);
    race_pair("t3_p1", 0, 1, 7, 1'b0, 1'b1, 7);
    race_pair("t3_p2", 2, 3, 7, 1'b1, 1'b0, 7);
    race_pair("t3_p3", 4, 5, 7, 1'b0, 1'b1, 7);
    collect("t3", 4'b0101, 1'b0, 1'b0);

    // 5: pair 2 never finishes and times out after exactly 64 enable cycles
    start_eval(5'd8);
    race_pair("t5_p0", 8, 9, 3, 1'b1, 1'b0, 3);
    race_pair("t5_p1", 10, 11, 3, 1'b1, 1'b0, 3);
    race_pair("t5_p2", 12, 13, 0, 1'b0, 1'b0, 64);
    race_pair("t5_p3", 14, 15, 3, 1'b1, 1'b0, 3);
    collect("t5", 4'b1011, 1'b0, 1'b1);

    // 4: pair 1 tie; the earlier timeout flag must be cleared by this start
    start_eval(5'd16);
    race_pair("t4_p0", 16, 17, 5, 1'b1, 1'b0, 5);
    race_pair("t4_p1", 18, 19, 5, 1'b1, 1'b1, 5);
    race_pair("t4_p2", 20, 21, 5, 1'b1, 1'b0, 5);
    race_pair("t4_p3", 22, 23, 5, 1'b1, 1'b0, 5);
    wait_valid("t4");
    check("t4_resp", 32'(host.resp), 32'b1101);
    check("t4_tie", 32'(host.tie_flag), 32'd1);
    check("t4_to", 32'(host.to_flag), 32'd0);

    // 6: host stalls 20 cycles in DONE while start is pulsed
    for (int i = 0; i < 20; i++) begin
      host.start     = (i == 5);
      host.challenge = 5'd7;
      @(negedge clk);
      check("t6_hold_valid", 32'(host.resp_valid), 32'd1);
      check("t6_hold_resp", 32'(host.resp), 32'b1101);
      check("t6_hold_busy", 32'(host.busy), 32'd1);
    end
    host.start = 1'b0;
    check("t6_hold_sel_a", 32'(sel_a), 32'd22);
    host.resp_ready = 1'b1;
    @(negedge clk);
    host.resp_ready = 1'b0;
    check("t6_valid_drop", 32'(host.resp_valid), 32'd0);
    check("t6_busy_drop", 32'(host.busy), 32'd0);
    check("t6_idle_tie_held", 32'(host.tie_flag), 32'd1);
    start_eval(5'd5);
    check("t6_restart_sel_a", 32'(sel_a), 32'd5);
    check("t6_restart_sel_b", 32'(sel_b), 32'd6);
    check("t6_restart_tie_clr", 32'(host.tie_flag), 32'd0);
    check("t6_restart_resp_clr", 32'(host.resp), 32'd0);

    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
